// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the 16-bit pipeline: datapath widths, ALU operation
//   codes, and the packed ID->EX pipeline-register layout with its bubble value.
//   Imported by the ALU, the decoder and the ID->EX operand stage.
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int DATA_W = 16;  // operand/result width, signed two's complement
  localparam int REG_W  = 3;   // register address width; register 0 reads zero

  // ALU operation codes. 2'b11 is reserved: carried through unchanged,
  // the ALU's behaviour for it is undefined.
  typedef enum logic [1:0] {
    ALU_OP_AND  = 2'b00,
    ALU_OP_ADD  = 2'b01,
    ALU_OP_SUB  = 2'b10,
    ALU_OP_RSVD = 2'b11
  } alu_op_e;

  // Contents of the ID->EX pipeline register.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_W-1:0]  rd;
    alu_op_e           alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_reg_t;

  // A bubble never writes, never triggers a hazard and never forwards: every
  // field is zero, which also makes its source registers read as R0.
  function automatic ex_reg_t ex_bubble();
    ex_reg_t b;
    b        = '0;
    b.alu_op = ALU_OP_AND;
    return b;
  endfunction

endpackage : pipeline_pkg

// File: rtl/forward_mux.sv
// -----------------------------------------------------------------------------
// forward_mux
//   Selects the value of one source operand in EX: the EX/MEM ALU result, the
//   MEM/WB writeback value, or the register-file data captured in ID.
//   Register 0 always yields zero and is never forwarded.
//
//   i_rs             source register number held in the EX register
//   i_rf_data        register-file read data captured in ID
//   i_exm_rd/_reg_write/_mem_read/_result   EX/MEM tags and ALU result
//   i_mwb_rd/_reg_write/_data               MEM/WB tags and writeback value
//   o_operand        resolved operand value
// -----------------------------------------------------------------------------
module forward_mux
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0]  i_rs,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic [REG_W-1:0]  i_exm_rd,
  input  logic              i_exm_reg_write,
  input  logic              i_exm_mem_read,
  input  logic [DATA_W-1:0] i_exm_result,
  input  logic [REG_W-1:0]  i_mwb_rd,
  input  logic              i_mwb_reg_write,
  input  logic [DATA_W-1:0] i_mwb_data,
  output logic [DATA_W-1:0] o_operand
);

  logic w_rs_zero;
  logic w_hit_exm;
  logic w_hit_mwb;

  assign w_rs_zero = (i_rs == '0);

  // A load in EX/MEM has no data yet (only its address), so it cannot forward;
  // the load-use stall guarantees it is picked up from MEM/WB a cycle later.
  assign w_hit_exm = i_exm_reg_write & ~i_exm_mem_read & (i_exm_rd == i_rs);
  assign w_hit_mwb = i_mwb_reg_write & (i_mwb_rd == i_rs);

  // The younger producer (EX/MEM) wins when both stages target the same rd.
  // MEM/WB also covers a register-file write happening in this same cycle.
  always_comb begin
    if (w_rs_zero) begin
      o_operand = '0;
    end else if (w_hit_exm) begin
      o_operand = i_exm_result;
    end else if (w_hit_mwb) begin
      o_operand = i_mwb_data;
    end else begin
      o_operand = i_rf_data;
    end
  end

endmodule : forward_mux

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID->EX pipeline register and operand-delivery stage for the 16-bit ALU.
//   Captures decoded operands/control, resolves operands through EX/MEM and
//   MEM/WB forwarding, stalls ID for one cycle on a load-use hazard (loading a
//   bubble into EX) and kills the instruction entering EX on a branch flush.
//
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_*                       decoded instruction in the ID slot
//   flush                      branch taken: the instruction entering EX dies
//   exm_*                      EX/MEM destination tags and ALU result
//   mwb_*                      MEM/WB destination tags and writeback value
//   stall_id                   hold PC and IF/ID this cycle (combinational)
//   ex_valid                   EX slot holds a real instruction
//   ex_a, ex_b, ex_alu_op      straight to ALU A, B and ALUop
//   ex_store_data              forwarded rs2 for stores
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write   registered control
// -----------------------------------------------------------------------------
module id_ex_operand_stage
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  alu_op_e           id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [DATA_W-1:0] exm_alu_result,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output alu_op_e           ex_alu_op,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

  ex_reg_t           r_ex;
  ex_reg_t           w_ex_next;
  logic              w_load_use;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;

  // A load sitting in EX produces its data only in MEM/WB, one cycle too late
  // for a dependent instruction in ID. rs2 only counts when the instruction
  // actually reads it (ALU B or store data).
  assign w_load_use = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                      ((r_ex.rd == id_rs1) | (id_uses_rs2 & (r_ex.rd == id_rs2)));

  // Flush kills the dependent instruction anyway, so holding ID would only
  // re-present a dead instruction.
  assign stall_id = w_load_use & ~flush;

  // NOTE: assign a default to every combinational output first; a path that
  // skips the assignment would otherwise infer a latch.
  always_comb begin
    w_ex_next = ex_bubble();
    if (id_valid && !flush && !w_load_use) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rs1       = id_rs1;
      w_ex_next.rs2       = id_rs2;
      w_ex_next.rs1_data  = id_rs1_data;
      w_ex_next.rs2_data  = id_rs2_data;
      w_ex_next.imm       = id_imm;
      w_ex_next.use_imm   = id_use_imm;
      w_ex_next.rd        = id_rd;
      w_ex_next.alu_op    = id_alu_op;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
      w_ex_next.mem_write = id_mem_write;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= ex_bubble();
    end else begin
      r_ex <= w_ex_next;
    end
  end

  // Forwarding is resolved in EX against the producers currently one and two
  // stages ahead, so the registered RF data is only a fallback.
  forward_mux u_fwd_rs1 (
    .i_rs            (r_ex.rs1),
    .i_rf_data       (r_ex.rs1_data),
    .i_exm_rd        (exm_rd),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_mem_read  (exm_mem_read),
    .i_exm_result    (exm_alu_result),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_data      (mwb_data),
    .o_operand       (w_rs1_val)
  );

  forward_mux u_fwd_rs2 (
    .i_rs            (r_ex.rs2),
    .i_rf_data       (r_ex.rs2_data),
    .i_exm_rd        (exm_rd),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_mem_read  (exm_mem_read),
    .i_exm_result    (exm_alu_result),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_data      (mwb_data),
    .o_operand       (w_rs2_val)
  );

  assign ex_valid      = r_ex.valid;
  assign ex_a          = w_rs1_val;
  assign ex_b          = r_ex.use_imm ? r_ex.imm : w_rs2_val;
  assign ex_store_data = w_rs2_val;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_rd         = r_ex.rd;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;

endmodule : id_ex_operand_stage
